// File: rtl/cpu_pkg.sv
// Shared CPU sequencing definitions: phase states, one-hot phase codes and the
// halt opcode. Used by the phase controller and the writeback stage.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [3:0] PH_NONE   = 4'b0000;
    localparam logic [3:0] PH_FETCH  = 4'b0001;
    localparam logic [3:0] PH_DECODE = 4'b0010;
    localparam logic [3:0] PH_EXEC   = 4'b0100;
    localparam logic [3:0] PH_WRITE  = 4'b1000;

    localparam logic [5:0] OP_HALT = 6'b111111;

    function automatic logic [3:0] phase_of(input state_e s);
        logic [3:0] ph;
        ph = PH_NONE;
        case (s)
            ST_FETCH:  ph = PH_FETCH;
            ST_DECODE: ph = PH_DECODE;
            ST_EXEC:   ph = PH_EXEC;
            ST_WRITE:  ph = PH_WRITE;
            default:   ph = PH_NONE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/cpu_phase_ctrl.sv
// Multi-cycle instruction sequencer: one-hot FETCH/DECODE/EXEC/WRITE phase
// vector with run/step control, memory stalls, halting and a retire counter.
module cpu_phase_ctrl
    import cpu_pkg::*;
#(
    parameter int         CNT_W   = 32,
    parameter logic [5:0] OP_HALT = cpu_pkg::OP_HALT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             mem_busy,
    input  logic [5:0]       op,
    output logic [3:0]       start,
    output logic [5:0]       op_q,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e           state_q, state_d;
    logic [5:0]       op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halt_pend_q, halt_pend_d;
    logic [3:0]       start_q, start_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic [5:0]       op_r;

    always_comb begin
        state_d     = state_q;
        op_d        = op_r;
        cnt_d       = cnt_q;
        halt_pend_d = halt_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (halt_pend_q)      state_d = ST_HALT;
                else if (run || step) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (!mem_busy) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                op_d    = op;
                state_d = (op == OP_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (!mem_busy) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (halt_pend_q) state_d = ST_HALT;
                else if (run)    state_d = ST_FETCH;
                else             state_d = ST_IDLE;
            end
            ST_HALT: begin
                if (resume) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A request raised on the cycle HALT is entered is consumed by that entry.
        if (halt_req && (state_q != ST_HALT))             halt_pend_d = 1'b1;
        if ((state_d == ST_HALT) && (state_q != ST_HALT)) halt_pend_d = 1'b0;

        // Outputs are decoded from the next state so they are plain flops.
        start_d  = phase_of(state_d);
        busy_d   = (start_d != PH_NONE);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_r        <= '0;
            cnt_q       <= '0;
            halt_pend_q <= 1'b0;
            start_q     <= PH_NONE;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_r        <= op_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
        end
    end

    assign start     = start_q;
    assign op_q      = op_r;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Bench for cpu_phase_ctrl: directed scenarios plus a randomized run, all
// checked against an instruction-level reference model kept in the bench.
module tb_cpu_phase_ctrl;

    localparam int CNT_W = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    // Model phase numbering: 0 idle, 1..4 = fetch..write, 5 halted.
    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_DEC   = 2;
    localparam int P_EXEC  = 3;
    localparam int P_WRITE = 4;
    localparam int P_HALT  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             run, step, halt_req, resume, mem_busy;
    logic [5:0]       op;
    logic [3:0]       start;
    logic [5:0]       op_q;
    logic             busy, halted;
    logic [CNT_W-1:0] instr_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int         m_ph;
    bit         m_pend;
    int         m_cnt;
    logic [5:0] m_op;

    cpu_phase_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .halt_req(halt_req),
        .resume(resume), .mem_busy(mem_busy), .op(op), .start(start),
        .op_q(op_q), .busy(busy), .halted(halted), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [3:0] exp_start();
        return (m_ph >= P_FETCH && m_ph <= P_WRITE) ? 4'(1 << (m_ph - 1)) : 4'd0;
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_pend = 0; m_cnt = 0; m_op = '0;
    endtask

    task automatic model_edge();
        int nxt;
        nxt = m_ph;
        if (m_ph == P_IDLE) begin
            if (m_pend)           nxt = P_HALT;
            else if (run || step) nxt = P_FETCH;
        end else if (m_ph == P_FETCH || m_ph == P_EXEC) begin
            if (!mem_busy) nxt = m_ph + 1;
        end else if (m_ph == P_DEC) begin
            m_op = op;
            nxt  = (op == 6'h3f) ? P_HALT : P_EXEC;
        end else if (m_ph == P_WRITE) begin
            m_cnt = (m_cnt + 1) % CNT_MOD;
            nxt   = m_pend ? P_HALT : (run ? P_FETCH : P_IDLE);
        end else if (resume) begin
            nxt = P_IDLE;
        end
        if (halt_req && m_ph != P_HALT)   m_pend = 1;
        if (nxt == P_HALT && m_ph != P_HALT) m_pend = 0;
        m_ph = nxt;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        run = 0; step = 0; halt_req = 0; resume = 0; mem_busy = 0; op = 6'h01;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain_to_idle(input string name);
        int n;
        run = 0; n = 0;
        while (busy === 1'b1 && n < 40) begin tick(); n++; end
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL %s drain: busy=%b want 0 after %0d cycles", name, busy, n);
        else pass_cnt++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset();
        #3;
        total_cnt++;
        if ({start, busy, halted, op_q, instr_cnt} !== '0)
            $display("FAIL reset outputs: start=%b busy=%b halted=%b op_q=%h cnt=%0d want all 0",
                     start, busy, halted, op_q, instr_cnt);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        tick();
        total_cnt++;
        if (start !== 4'd0 || busy !== 1'b0) $display("FAIL reset idle: start=%b busy=%b want 0 0", start, busy);
        else pass_cnt++;
    endtask

    task automatic test_free_run();
        logic [3:0] seq [4];
        int w_hits;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
        do_reset();
        run = 1; op = 6'b000001; w_hits = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (start[3]) w_hits++;
            total_cnt++;
            if (start !== seq[i % 4]) $display("FAIL free_run start[%0d]: got %b want %b", i, start, seq[i % 4]);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (instr_cnt !== CNT_W'(3) || start !== 4'b0001)
            $display("FAIL free_run count: cnt=%0d start=%b want 3 0001", instr_cnt, start);
        else pass_cnt++;
        total_cnt++;
        if (w_hits !== 3) $display("FAIL free_run write_width: got %0d write cycles want 3", w_hits);
        else pass_cnt++;
        drain_to_idle("free_run");
    endtask

    task automatic test_stall();
        bit mb [9] = '{1, 1, 1, 0, 0, 1, 1, 0, 0};
        int fetch_c, exec_c, busy_c, cnt0;
        cnt0 = m_cnt;
        run = 0; step = 1; mem_busy = 1;
        tick();
        step = 0;
        fetch_c = (start == 4'b0001); exec_c = 0; busy_c = busy;
        for (int i = 0; i < 9; i++) begin
            mem_busy = mb[i];
            tick();
            if (start == 4'b0001) fetch_c++;
            if (start == 4'b0100) exec_c++;
            if (busy) busy_c++;
        end
        mem_busy = 0;
        total_cnt++;
        if (fetch_c !== 4) $display("FAIL stall fetch_len: got %0d want 4", fetch_c); else pass_cnt++;
        total_cnt++;
        if (exec_c !== 3) $display("FAIL stall exec_len: got %0d want 3", exec_c); else pass_cnt++;
        total_cnt++;
        if (busy_c !== 9) $display("FAIL stall instr_len: got %0d want 9", busy_c); else pass_cnt++;
        total_cnt++;
        if (instr_cnt !== CNT_W'((cnt0 + 1) % CNT_MOD) || busy !== 1'b0)
            $display("FAIL stall count: cnt=%0d busy=%b want %0d 0", instr_cnt, busy, (cnt0 + 1) % CNT_MOD);
        else pass_cnt++;
    endtask

    task automatic test_step();
        do_reset();
        step = 1; tick();
        step = 0; tick();
        step = 1; tick();
        step = 0;
        drain_to_idle("step");
        repeat (3) tick();
        total_cnt++;
        if (instr_cnt !== CNT_W'(1) || start !== 4'd0 || busy !== 1'b0)
            $display("FAIL step single: cnt=%0d start=%b busy=%b want 1 0000 0", instr_cnt, start, busy);
        else pass_cnt++;
    endtask

    task automatic test_halt_op();
        op = 6'b111111;
        step = 1; tick();
        step = 0; tick(); tick();
        total_cnt++;
        if (halted !== 1'b1 || start !== 4'd0 || instr_cnt !== CNT_W'(1) || op_q !== 6'h3f)
            $display("FAIL halt_op enter: halted=%b start=%b cnt=%0d op_q=%h want 1 0000 1 3f",
                     halted, start, instr_cnt, op_q);
        else pass_cnt++;
        run = 1; step = 1; tick(); tick();
        run = 0; step = 0;
        total_cnt++;
        if (halted !== 1'b1 || busy !== 1'b0) $display("FAIL halt_op sticky: halted=%b busy=%b want 1 0", halted, busy);
        else pass_cnt++;
        resume = 1; tick();
        resume = 0;
        total_cnt++;
        if (halted !== 1'b0 || busy !== 1'b0 || start !== 4'd0)
            $display("FAIL halt_op resume: halted=%b busy=%b start=%b want 0 0 0000", halted, busy, start);
        else pass_cnt++;
        op = 6'h01;
    endtask

    task automatic test_halt_req();
        int n, cnt_exp, fetch_seen;
        run = 1; op = 6'h05; n = 0;
        while (start !== 4'b0100 && n < 20) begin tick(); n++; end
        total_cnt++;
        if (start !== 4'b0100) $display("FAIL halt_req reach_exec: start=%b want 0100", start); else pass_cnt++;
        cnt_exp = (m_cnt + 1) % CNT_MOD;
        halt_req = 1; tick();
        halt_req = 0;
        total_cnt++;
        if (start !== 4'b1000) $display("FAIL halt_req write_kept: start=%b want 1000", start); else pass_cnt++;
        tick();
        total_cnt++;
        if (halted !== 1'b1 || instr_cnt !== CNT_W'(cnt_exp))
            $display("FAIL halt_req halted: halted=%b cnt=%0d want 1 %0d", halted, instr_cnt, cnt_exp);
        else pass_cnt++;
        fetch_seen = 0;
        repeat (5) begin tick(); if (start[0]) fetch_seen++; end
        total_cnt++;
        if (fetch_seen !== 0 || halted !== 1'b1) $display("FAIL halt_req no_fetch: fetches=%0d halted=%b want 0 1", fetch_seen, halted);
        else pass_cnt++;
        run = 0; resume = 1; tick();
        resume = 0;
    endtask

    task automatic test_reset_mid_write();
        int n;
        run = 1; n = 0;
        while (start !== 4'b1000 && n < 20) begin tick(); n++; end
        #2 rst = 1'b1;
        model_reset();
        #1;
        total_cnt++;
        if (start !== 4'd0 || instr_cnt !== '0 || busy !== 1'b0)
            $display("FAIL reset_mid_write: start=%b cnt=%0d busy=%b want 0000 0 0", start, instr_cnt, busy);
        else pass_cnt++;
        run = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        run = 1;
        repeat (69) tick();
        total_cnt++;
        if (instr_cnt !== CNT_W'(1)) $display("FAIL wrap count: got %0d want 1", instr_cnt); else pass_cnt++;
        drain_to_idle("wrap");
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) run = ~run;
            step     = ($urandom_range(0, 3) == 0);
            halt_req = ($urandom_range(0, 24) == 0);
            resume   = ($urandom_range(0, 5) == 0);
            mem_busy = ($urandom_range(0, 2) == 0);
            op       = ($urandom_range(0, 9) == 0) ? 6'h3f : 6'($urandom_range(0, 62));
            tick();
            total_cnt++;
            if (start !== exp_start() || busy !== (exp_start() != 0) || halted !== (m_ph == P_HALT))
                $display("FAIL random phase @%0d: start=%b busy=%b halted=%b want %b %b %b",
                         i, start, busy, halted, exp_start(), exp_start() != 0, m_ph == P_HALT);
            else pass_cnt++;
            total_cnt++;
            if (op_q !== m_op || instr_cnt !== CNT_W'(m_cnt))
                $display("FAIL random data @%0d: op_q=%h cnt=%0d want %h %0d", i, op_q, instr_cnt, m_op, m_cnt);
            else pass_cnt++;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_step();
        test_halt_op();
        test_halt_req();
        test_reset_mid_write();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
